// File: rtl/matmul_out_collector.sv
// Output collector for tiled systolic matmul: captures one row per tile per valid cycle, then drains tile-major.
// Define MATMUL_OUT_COLLECTOR_ERR_EN to enable sticky misuse detection on err; otherwise err is tied low.
module matmul_out_collector #(
    parameter  int DWIDTH    = 8,
    parameter  int TILE_SIZE = 16,
    parameter  int NUM_TILES = 2,
    parameter  int AWIDTH    = 7,
    parameter  int DEPTH     = 128,
    localparam int RW        = TILE_SIZE * DWIDTH,
    localparam int TW        = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    start,
    input  logic [AWIDTH:0]         num_rows,
    input  logic                    c_valid,
    input  logic [NUM_TILES*RW-1:0] c_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [RW-1:0]           out_data,
    output logic [TW-1:0]           out_tile,
    output logic [AWIDTH-1:0]       out_row,
    output logic                    out_last,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);
    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, DONE} state_e;

    typedef struct packed {
        logic [RW-1:0]     data;
        logic [TW-1:0]     tile;
        logic [AWIDTH-1:0] row;
        logic              last;
    } beat_t;

    state_e            state_q, state_d;
    logic [AWIDTH:0]   n_q, n_d, n_m1, n_clamp;
    logic [AWIDTH-1:0] wr_cnt_q, wr_cnt_d, rd_row_q, rd_row_d;
    logic [TW-1:0]     rd_tile_q, rd_tile_d;
    logic              rd_act_q, rd_act_d;
    logic              pend_q, pend_d;
    logic [TW-1:0]     pend_tile_q, pend_tile_d;
    logic [AWIDTH-1:0] pend_row_q, pend_row_d;
    logic              pend_last_q, pend_last_d;
    logic [1:0]        q_cnt_q, q_cnt_d;
    beat_t             s0_q, s0_d, s1_q, s1_d, new_beat;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic              wr_en, rd_en, pop, last_rd;
    logic [2:0]        occ;
    logic [RW-1:0]     rd_data_q;
    logic [RW-1:0]     mem [NUM_TILES][DEPTH];

    assign n_m1     = n_q - 1'b1;
    assign n_clamp  = (num_rows > (AWIDTH+1)'(DEPTH)) ? (AWIDTH+1)'(DEPTH) : num_rows;
    assign pop      = out_valid_q & out_ready;
    assign last_rd  = (rd_tile_q == TW'(NUM_TILES - 1)) && ({1'b0, rd_row_q} == n_m1);
    assign new_beat = '{data: rd_data_q, tile: pend_tile_q, row: pend_row_q, last: pend_last_q};
    // Slots held after this cycle's pop plus the read in flight; a new read must still fit in two.
    assign occ      = {1'b0, q_cnt_q} + {2'b00, pend_q} - {2'b00, pop};

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        wr_cnt_d    = wr_cnt_q;
        rd_row_d    = rd_row_q;
        rd_tile_d   = rd_tile_q;
        rd_act_d    = rd_act_q;
        q_cnt_d     = q_cnt_q;
        s0_d        = s0_q;
        s1_d        = s1_q;
        wr_en       = 1'b0;
        rd_en       = 1'b0;

        case (state_q)
            IDLE: if (start) begin
                n_d      = n_clamp;
                wr_cnt_d = '0;
                state_d  = (n_clamp == '0) ? DONE : CAPTURE;
            end
            CAPTURE: if (c_valid) begin
                wr_en    = 1'b1;
                wr_cnt_d = wr_cnt_q + 1'b1;
                if ({1'b0, wr_cnt_q} == n_m1) begin
                    state_d   = DRAIN;
                    rd_row_d  = '0;
                    rd_tile_d = '0;
                    rd_act_d  = 1'b1;
                end
            end
            DRAIN: if (pop && s0_q.last) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (rd_act_q && occ < 3'd2) begin
            rd_en = 1'b1;
            if (last_rd) begin
                rd_act_d = 1'b0;
            end else if ({1'b0, rd_row_q} == n_m1) begin
                rd_row_d  = '0;
                rd_tile_d = rd_tile_q + 1'b1;
            end else begin
                rd_row_d = rd_row_q + 1'b1;
            end
        end
        pend_d      = rd_en;
        pend_tile_d = rd_tile_q;
        pend_row_d  = rd_row_q;
        pend_last_d = last_rd;

        case ({pend_q, pop})
            2'b10: begin
                if (q_cnt_q == 2'd0) s0_d = new_beat;
                else                 s1_d = new_beat;
                q_cnt_d = q_cnt_q + 2'd1;
            end
            2'b01: begin
                s0_d    = s1_q;
                q_cnt_d = q_cnt_q - 2'd1;
            end
            2'b11: begin
                if (q_cnt_q == 2'd2) begin
                    s0_d = s1_q;
                    s1_d = new_beat;
                end else begin
                    s0_d = new_beat;
                end
            end
            default: ;
        endcase

        out_valid_d = (q_cnt_d != 2'd0);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            n_q         <= '0;
            wr_cnt_q    <= '0;
            rd_row_q    <= '0;
            rd_tile_q   <= '0;
            rd_act_q    <= 1'b0;
            pend_q      <= 1'b0;
            pend_tile_q <= '0;
            pend_row_q  <= '0;
            pend_last_q <= 1'b0;
            q_cnt_q     <= '0;
            s0_q        <= '0;
            s1_q        <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_row_q    <= rd_row_d;
            rd_tile_q   <= rd_tile_d;
            rd_act_q    <= rd_act_d;
            pend_q      <= pend_d;
            pend_tile_q <= pend_tile_d;
            pend_row_q  <= pend_row_d;
            pend_last_q <= pend_last_d;
            q_cnt_q     <= q_cnt_d;
            s0_q        <= s0_d;
            s1_q        <= s1_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned t = 0; t < NUM_TILES; t++) begin
                mem[t][wr_cnt_q] <= c_data[t*RW +: RW];
            end
        end
        if (rd_en) rd_data_q <= mem[rd_tile_q][rd_row_q];
    end

    assign out_valid = out_valid_q;
    assign out_data  = s0_q.data;
    assign out_tile  = s0_q.tile;
    assign out_row   = s0_q.row;
    assign out_last  = s0_q.last;
    assign busy      = busy_q;
    assign done      = done_q;

`ifdef MATMUL_OUT_COLLECTOR_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (start && state_q != IDLE) err_d = 1'b1;
        if (c_valid && state_q != CAPTURE) err_d = 1'b1;
        if (start && state_q == IDLE && num_rows > (AWIDTH+1)'(DEPTH)) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) err_q <= 1'b0;
        else         err_q <= err_d;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_matmul_out_collector.sv
// Bench for matmul_out_collector: random row data, expected beat stream rebuilt from captured rows.
`timescale 1ns/1ps
module tb_matmul_out_collector;
    localparam int DW = 8, TS = 16, NT = 2, AW = 7, DEPTH = 128, RW = TS * DW;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              start = 1'b0;
    logic              c_valid = 1'b0;
    logic              out_ready = 1'b0;
    logic [AW:0]       num_rows = '0;
    logic [NT*RW-1:0]  c_data = '0;
    logic              out_valid, out_last, busy, done, err;
    logic [RW-1:0]     out_data;
    logic [0:0]        out_tile;
    logic [AW-1:0]     out_row;

    int compared = 0;
    int mismatched = 0;
    logic [RW-1:0] rows [NT][DEPTH];
    logic exp_err;

    matmul_out_collector #(
        .DWIDTH(DW), .TILE_SIZE(TS), .NUM_TILES(NT), .AWIDTH(AW), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start), .num_rows(num_rows),
        .c_valid(c_valid), .c_data(c_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tile(out_tile), .out_row(out_row), .out_last(out_last),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [RW-1:0] rand_row();
        logic [RW-1:0] v;
        for (int i = 0; i < RW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Starts a job, then feeds min(nr, DEPTH) rows with c_valid every gap-th cycle.
    // Returns at the negedge where the final row is being driven.
    task automatic capture(input int nr, input int gap, input bit pat);
        int n;
        logic [DW-1:0] b;
        logic [RW-1:0] row;
        n = (nr > DEPTH) ? DEPTH : nr;
        @(negedge clk);
        start = 1'b1;
        num_rows = nr[AW:0];
        @(negedge clk);
        start = 1'b0;
        num_rows = '0;
        check("busy_after_start", busy, 1);
        for (int r = 0; r < n; r++) begin
            for (int g = 0; g < gap - 1; g++) begin
                c_valid = 1'b0;
                @(negedge clk);
            end
            for (int t = 0; t < NT; t++) begin
                b = 8'hA0 + 8'(t * 16) + 8'(r);
                row = pat ? {TS{b}} : rand_row();
                rows[t][r] = row;
                c_data[t*RW +: RW] = row;
            end
            c_valid = 1'b1;
            if (r < n - 1) @(negedge clk);
        end
    endtask

    task automatic drain(input int n, input int rdy_pct, input bit inject);
        int total, idx, cyc, budget, et, er;
        bit seen, stall, rdy;
        logic [RW-1:0] h_data;
        logic [0:0] h_tile;
        logic [AW-1:0] h_row;
        logic h_last;
        total = NT * n;
        idx = 0;
        cyc = 0;
        budget = total * 40 + 20;
        seen = 0;
        stall = 0;
        while (idx < total && cyc < budget) begin
            @(negedge clk);
            cyc++;
            c_valid = 1'b0;
            if (inject) begin
                start = (cyc == 1) ? 1'b1 : 1'($urandom_range(0, 1));
                c_valid = 1'($urandom_range(0, 1));
                c_data = {rand_row(), rand_row()};
            end
            check("no_early_done", done, 0);
            if (out_valid && !seen) begin
                seen = 1;
                check("first_valid_lat", cyc, 3);
            end
            if (stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, h_data);
                check("stall_tile", out_tile, h_tile);
                check("stall_row", out_row, h_row);
                check("stall_last", out_last, h_last);
            end
            rdy = ($urandom_range(0, 99) < rdy_pct);
            out_ready = rdy;
            stall = 0;
            if (out_valid) begin
                if (rdy) begin
                    et = idx / n;
                    er = idx % n;
                    check("beat_data", out_data, rows[et][er]);
                    check("beat_tile", out_tile, et);
                    check("beat_row", out_row, er);
                    check("beat_last", out_last, (idx == total - 1));
                    idx++;
                end else begin
                    stall = 1;
                    h_data = out_data;
                    h_tile = out_tile;
                    h_row = out_row;
                    h_last = out_last;
                end
            end
        end
        check("drain_beats", idx, total);
        @(negedge clk);
        start = 1'b0;
        c_valid = 1'b0;
        out_ready = 1'b0;
        check("done_pulse", done, 1);
        check("done_busy", busy, 1);
        check("done_no_valid", out_valid, 0);
        @(negedge clk);
        check("done_clear", done, 0);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        int dcount, vcount, dcyc;
`ifdef MATMUL_OUT_COLLECTOR_ERR_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        // Reset with random inputs
        resetn = 1'b0;
        repeat (4) begin
            @(negedge clk);
            start = 1'($urandom_range(0, 1));
            c_valid = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            num_rows = (AW+1)'($urandom);
            c_data = {rand_row(), rand_row()};
        end
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_tile", out_tile, 0);
        check("rst_row", out_row, 0);
        check("rst_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        start = 1'b0;
        c_valid = 1'b0;
        out_ready = 1'b0;
        num_rows = '0;
        c_data = '0;
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy_after_rst", busy, 0);

        // Basic patterned job
        capture(4, 1, 1);
        drain(4, 100, 0);
        check("err_clean", err, 0);

        // Backpressure
        capture(16, 1, 0);
        drain(16, 30, 0);

        // Gapped capture
        capture(5, 3, 0);
        drain(5, 100, 0);

        // Zero-row job
        @(negedge clk);
        start = 1'b1;
        num_rows = '0;
        dcount = 0;
        vcount = 0;
        dcyc = 0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                dcount++;
                if (dcyc == 0) dcyc = c;
            end
            if (out_valid) vcount++;
        end
        check("n0_done_count", dcount, 1);
        check("n0_done_window", (dcyc >= 1 && dcyc <= 2), 1);
        check("n0_beats", vcount, 0);
        check("n0_busy", busy, 0);

        // Oversized request clamps to DEPTH
        capture(200, 1, 0);
        drain(DEPTH, 100, 0);
        check("err_oversize", err, exp_err);

        // Abort mid-drain
        capture(8, 1, 0);
        repeat (4) begin
            @(negedge clk);
            c_valid = 1'b0;
            out_ready = 1'b1;
        end
        resetn = 1'b0;
        #1;
        check("abort_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_err", err, 0);
        @(negedge clk);
        out_ready = 1'b0;
        resetn = 1'b1;
        dcount = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("abort_no_done", dcount, 0);
        check("abort_idle", busy, 0);

        // Start/c_valid during drain are ignored
        capture(6, 1, 0);
        drain(6, 100, 1);
        check("err_ignored_events", err, exp_err);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
